bus_sequencer: RTL and testbench
================================

// Module: bus_sequencer
// PURPOSE
//  Drives the set/enable strobes of the 8-bit register file. Each request is
//  one bus transfer: enable the source register or an immediate onto the bus,
//  pulse set on the destination, hold, release. Sits between the control
//  logic and the register/enabler array. It is the initiator for the register
//  set/en interface.
// PARAMETERS
//  N_REGS  8  number of registers on the bus; one en and one set line each
//  ADDR_W  3  register index width; N_REGS <= 2**ADDR_W
//  WIDTH   8  bus width in bits
// PORTS
//  clk        in   1       single clock; all state updates on posedge clk
//  rst        in   1       synchronous, active-high reset
//  req_valid  in   1       transfer request valid
//  req_ready  out  1       sequencer can accept a request this cycle
//  req_src    in   ADDR_W  source register index (ignored when req_imm_en=1)
//  req_dst    in   ADDR_W  destination register index
//  req_imm_en in   1       source is req_imm rather than a register
//  req_imm    in   WIDTH   immediate value driven onto the bus
//  reg_en     out  N_REGS  one-hot enable lines (register -> bus)
//  reg_set    out  N_REGS  one-hot set lines (bus -> register latch)
//  bus_drive  out  WIDTH   immediate onto bus; 0 when no immediate is active
//  bus_in     in   WIDTH   wired-OR bus value (all enabler outputs | bus_drive)
//  done       out  1       one-cycle pulse: transfer finished or rejected
//  done_err   out  1       valid with done; 1 = request rejected
//  done_data  out  WIDTH   bus value captured in SET; held until the next done
//  busy       out  1       1 in every state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE. reg_en, reg_set, bus_drive, done, done_err, done_data
//   are all 0. busy=0, req_ready=1. rst mid-transfer aborts on the next edge:
//   all strobes drop to 0 in that same cycle, and no done is issued.
//  Handshake: a request is accepted on a posedge with req_valid && req_ready.
//   Request fields are registered at acceptance. Later input changes are
//   ignored. req_ready = (state==IDLE).
//  Reject checks at acceptance; a rejected request goes to DONE with err=1
//   and produces no strobes:
//   - req_dst >= N_REGS;
//   - req_imm_en=0 and req_src >= N_REGS;
//   - req_imm_en=0 and req_src == req_dst.
//  FSM, one cycle per state:
//   IDLE   : all strobes 0. Accept -> ENABLE, or -> DONE if rejected.
//   ENABLE : reg_en[src]=1 or bus_drive=imm. reg_set=0. Lets the bus settle.
//   SET    : source kept on the bus; reg_set[dst]=1; done_data <= bus_in.
//   HOLD   : source kept on the bus; reg_set=0. Gives latch hold time.
//   DONE   : all strobes 0; done=1; done_err set. -> IDLE.
//  Latency: accept edge to done=1 is 4 cycles for a valid transfer and 1 cycle
//   for a rejected one. Throughput is one transfer every 5 cycles.
//  Invariants, checked every cycle:
//   - reg_en and reg_set are each one-hot or zero;
//   - reg_set is never high unless the source has been on the bus for a full
//     cycle before it;
//   - reg_en and bus_drive are never active together;
//   - reg_set is never asserted in the cycle the source is released.
//  Every strobe output is a register, not combinational from inputs, so no
//   glitches reach the latch-based register bits.
//  Back-to-back requests: a request held high is accepted in the IDLE cycle
//   that follows DONE. No request is dropped or duplicated.
// TESTING
//  T1 reset: hold rst 3 cycles with req_valid=1 -> all outputs 0, req_ready=1,
//     and no acceptance while rst=1.
//  T2 reg move: r2=0x5A, request src=2 dst=5 ->
//     - reg_en=0x04 for 3 cycles;
//     - reg_set=0x20 for 1 cycle, in the middle one;
//     - done=1 with done_data=0x5A; r5 reads 0x5A afterwards.
//  T3 immediate: imm=0xC3, dst=0 ->
//     - bus_drive=0xC3 for 3 cycles, reg_en stays 0;
//     - reg_set=0x01 once; done_data=0xC3.
//  T4 rejects: src=dst=3, then dst=9 with N_REGS=8 ->
//     done=1 and done_err=1 one cycle after acceptance; no strobe ever toggles.
//  T5 back-to-back: 3 queued requests with req_valid held high ->
//     done pulses at 5-cycle spacing; req_ready is high only in IDLE.
//  T6 abort: assert rst during SET -> strobes are 0 the next cycle, no done
//     is issued; a new request then completes normally.

Source files
------------

// File: rtl/bus_sequencer_if.sv
// Request/response and register-strobe signals between the control logic,
// the bus sequencer and the register/enabler array.
interface bus_sequencer_if #(
  parameter int N_REGS = 8,
  parameter int ADDR_W = 3,
  parameter int WIDTH  = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_src;
  logic [ADDR_W-1:0] req_dst;
  logic              req_imm_en;
  logic [WIDTH-1:0]  req_imm;
  logic [N_REGS-1:0] reg_en;
  logic [N_REGS-1:0] reg_set;
  logic [WIDTH-1:0]  bus_drive;
  logic [WIDTH-1:0]  bus_in;
  logic              done;
  logic              done_err;
  logic [WIDTH-1:0]  done_data;
  logic              busy;

  // master: control logic plus register array; slave: the sequencer itself
  modport master (
    output req_valid, req_src, req_dst, req_imm_en, req_imm, bus_in,
    input  req_ready, reg_en, reg_set, bus_drive, done, done_err, done_data, busy
  );

  modport slave (
    input  req_valid, req_src, req_dst, req_imm_en, req_imm, bus_in,
    output req_ready, reg_en, reg_set, bus_drive, done, done_err, done_data, busy
  );
endinterface

// File: rtl/bus_sequencer.sv
// Sequences one register-file bus transfer per request: source onto the bus,
// set pulse on the destination, hold, release, then report completion.
//
// state  | meaning
// IDLE   | ready for a request, all strobes low
// ENABLE | source on the bus, bus settling
// SET    | source on the bus, destination set strobe high, bus captured
// HOLD   | source on the bus, set low, latch hold time
// DONE   | strobes low, done pulse (with error flag for rejected requests)
module bus_sequencer #(
  parameter int N_REGS = 8,
  parameter int ADDR_W = 3,
  parameter int WIDTH  = 8
) (
  input logic            clk,
  input logic            rst,
  bus_sequencer_if.slave sb
);

  typedef enum logic [2:0] {IDLE, ENABLE, SET, HOLD, DONE} state_t;

  localparam logic [ADDR_W:0] N_REGS_W = (ADDR_W+1)'(N_REGS);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic              imm_en_q;
  logic [WIDTH-1:0]  imm_q;

  logic [N_REGS-1:0] reg_en_q, reg_en_nxt;
  logic [N_REGS-1:0] reg_set_q, reg_set_nxt;
  logic [WIDTH-1:0]  bus_drive_q, bus_drive_nxt;
  logic              done_q, done_nxt;
  logic              done_err_q, done_err_nxt;
  logic [WIDTH-1:0]  done_data_q;

  logic              accept, reject;
  logic [ADDR_W-1:0] cur_src, cur_dst;
  logic              cur_imm_en;
  logic [WIDTH-1:0]  cur_imm;

  function automatic logic [N_REGS-1:0] decode(input logic [ADDR_W-1:0] idx);
    logic [N_REGS-1:0] v;
    v = '0;
    for (int i = 0; i < N_REGS; i++) begin
      if (idx == ADDR_W'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  // In IDLE the strobes for the first cycle come straight from the request,
  // afterwards from the fields captured at acceptance.
  assign cur_src    = (state == IDLE) ? sb.req_src    : src_q;
  assign cur_dst    = (state == IDLE) ? sb.req_dst    : dst_q;
  assign cur_imm_en = (state == IDLE) ? sb.req_imm_en : imm_en_q;
  assign cur_imm    = (state == IDLE) ? sb.req_imm    : imm_q;

  assign accept = (state == IDLE) && sb.req_valid;
  assign reject = ({1'b0, sb.req_dst} >= N_REGS_W) ||
                  (!sb.req_imm_en && (({1'b0, sb.req_src} >= N_REGS_W) ||
                                      (sb.req_src == sb.req_dst)));

  always_comb begin
    state_nxt     = state;
    reg_en_nxt    = '0;
    reg_set_nxt   = '0;
    bus_drive_nxt = '0;
    done_nxt      = 1'b0;
    done_err_nxt  = 1'b0;

    case (state)
      IDLE:    if (sb.req_valid) state_nxt = reject ? DONE : ENABLE;
      ENABLE:  state_nxt = SET;
      SET:     state_nxt = HOLD;
      HOLD:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    if (state_nxt == ENABLE || state_nxt == SET || state_nxt == HOLD) begin
      if (cur_imm_en) bus_drive_nxt = cur_imm;
      else            reg_en_nxt    = decode(cur_src);
    end
    if (state_nxt == SET) reg_set_nxt = decode(cur_dst);
    if (state_nxt == DONE) begin
      done_nxt     = 1'b1;
      done_err_nxt = (state == IDLE);
    end
  end

  // Strobes are registered so nothing combinational reaches the latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      imm_en_q    <= 1'b0;
      imm_q       <= '0;
      reg_en_q    <= '0;
      reg_set_q   <= '0;
      bus_drive_q <= '0;
      done_q      <= 1'b0;
      done_err_q  <= 1'b0;
      done_data_q <= '0;
    end else begin
      state       <= state_nxt;
      reg_en_q    <= reg_en_nxt;
      reg_set_q   <= reg_set_nxt;
      bus_drive_q <= bus_drive_nxt;
      done_q      <= done_nxt;
      done_err_q  <= done_err_nxt;
      if (accept) begin
        src_q    <= sb.req_src;
        dst_q    <= sb.req_dst;
        imm_en_q <= sb.req_imm_en;
        imm_q    <= sb.req_imm;
      end
      if (state == SET) done_data_q <= sb.bus_in;
    end
  end

  assign sb.req_ready = (state == IDLE);
  assign sb.busy      = (state != IDLE);
  assign sb.reg_en    = reg_en_q;
  assign sb.reg_set   = reg_set_q;
  assign sb.bus_drive = bus_drive_q;
  assign sb.done      = done_q;
  assign sb.done_err  = done_err_q;
  assign sb.done_data = done_data_q;

endmodule

// File: tb/tb_bus_sequencer.sv
// Bench for bus_sequencer: register-file model on the bus, request driver that
// queues expected completions, and a monitor checking completions and strobes.
module tb_bus_sequencer;

  localparam int N_REGS = 8;
  localparam int ADDR_W = 4;
  localparam int WIDTH  = 8;

  typedef struct {
    int         due;
    logic       err;
    logic [7:0] data;
    logic [3:0] src;
    logic [3:0] dst;
    logic       imm_en;
    logic [7:0] imm;
  } exp_t;

  logic clk;
  logic rst;
  logic rst_d = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_fail = 0;

  exp_t q[$];
  exp_t mon_e;
  logic [7:0] rf [N_REGS];

  logic [7:0] en_or, set_or, drv_or;
  int         en_cnt, set_cnt, drv_cnt;
  logic       prev_src_on, prev_set, src_on;

  bus_sequencer_if #(.N_REGS(N_REGS), .ADDR_W(ADDR_W), .WIDTH(WIDTH)) sbus ();

  bus_sequencer #(.N_REGS(N_REGS), .ADDR_W(ADDR_W), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sbus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_d <= rst;
  end

  function automatic logic [7:0] init_val(input int i);
    return (i == 2) ? 8'h5A : 8'(8'h30 + i);
  endfunction

  // Register file with wired-OR enablers
  always @(posedge clk) begin
    for (int i = 0; i < N_REGS; i++) begin
      if (rst) rf[i] <= init_val(i);
      else if (sbus.reg_set[i]) rf[i] <= sbus.bus_in;
    end
  end

  always_comb begin
    logic [7:0] v;
    v = sbus.bus_drive;
    for (int i = 0; i < N_REGS; i++) begin
      if (sbus.reg_en[i]) v = v | rf[i];
    end
    sbus.bus_in = v;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end else begin
      n_pass++;
    end
  endtask

  task automatic clear_acc();
    en_or = '0; set_or = '0; drv_or = '0;
    en_cnt = 0; set_cnt = 0; drv_cnt = 0;
  endtask

  initial clear_acc();

  always @(negedge clk) begin
    if (rst_d) begin
      check_eq("rst_outs",
               {sbus.reg_en, sbus.reg_set, sbus.bus_drive, sbus.done, sbus.done_err,
                sbus.done_data, sbus.busy, sbus.req_ready}, 64'd1);
      q.delete();
      clear_acc();
      prev_src_on = 1'b0;
      prev_set    = 1'b0;
    end else begin
      src_on = (sbus.reg_en != 0) || (sbus.bus_drive != 0);
      check_eq("en_onehot0", 64'($countones(sbus.reg_en) <= 1), 64'd1);
      check_eq("set_onehot0", 64'($countones(sbus.reg_set) <= 1), 64'd1);
      check_eq("en_drive_excl", 64'((sbus.reg_en != 0) && (sbus.bus_drive != 0)), 64'd0);
      if (sbus.reg_set != 0) check_eq("set_after_src", 64'(prev_src_on), 64'd1);
      if (prev_set) check_eq("set_before_release", 64'(src_on), 64'd1);
      check_eq("req_ready", 64'(sbus.req_ready), 64'(q.size() == 0));
      check_eq("busy", 64'(sbus.busy), 64'(q.size() != 0));

      en_or  = en_or | sbus.reg_en;
      set_or = set_or | sbus.reg_set;
      drv_or = drv_or | sbus.bus_drive;
      if (sbus.reg_en != 0)    en_cnt++;
      if (sbus.reg_set != 0)   set_cnt++;
      if (sbus.bus_drive != 0) drv_cnt++;

      if (sbus.done) begin
        if (q.size() == 0) begin
          check_eq("done_unexpected", 64'(sbus.done), 64'd0);
        end else begin
          mon_e = q.pop_front();
          check_eq("done_cycle", 64'(cyc), 64'(mon_e.due));
          check_eq("done_err", 64'(sbus.done_err), 64'(mon_e.err));
          check_eq("en_lines", 64'(en_or),
                   (mon_e.err || mon_e.imm_en) ? 64'd0 : 64'(8'(1) << mon_e.src));
          check_eq("set_lines", 64'(set_or),
                   mon_e.err ? 64'd0 : 64'(8'(1) << mon_e.dst));
          check_eq("drive_val", 64'(drv_or),
                   (mon_e.err || !mon_e.imm_en) ? 64'd0 : 64'(mon_e.imm));
          check_eq("en_cycles", 64'(en_cnt), (mon_e.err || mon_e.imm_en) ? 64'd0 : 64'd3);
          check_eq("set_cycles", 64'(set_cnt), mon_e.err ? 64'd0 : 64'd1);
          check_eq("drive_cycles", 64'(drv_cnt), (mon_e.err || !mon_e.imm_en) ? 64'd0 : 64'd3);
          if (!mon_e.err) begin
            check_eq("done_data", 64'(sbus.done_data), 64'(mon_e.data));
            check_eq("dst_reg", 64'(rf[mon_e.dst[2:0]]), 64'(mon_e.data));
          end
        end
        clear_acc();
      end else if (q.size() != 0 && cyc > q[0].due) begin
        check_eq("done_missing", 64'(sbus.done), 64'd1);
        void'(q.pop_front());
        clear_acc();
      end
      prev_src_on = src_on;
      prev_set    = (sbus.reg_set != 0);
    end
  end

  task automatic send(input logic [3:0] src, input logic [3:0] dst,
                      input logic imm_en, input logic [7:0] imm);
    exp_t e;
    logic err;
    sbus.req_src    = src;
    sbus.req_dst    = dst;
    sbus.req_imm_en = imm_en;
    sbus.req_imm    = imm;
    sbus.req_valid  = 1'b1;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      #1;
      if (sbus.req_ready && !rst) begin
        err      = (dst >= 4'(N_REGS)) || (!imm_en && ((src >= 4'(N_REGS)) || (src == dst)));
        e.due    = cyc + (err ? 1 : 4);
        e.err    = err;
        e.data   = imm_en ? imm : rf[src[2:0]];
        e.src    = src;
        e.dst    = dst;
        e.imm_en = imm_en;
        e.imm    = imm;
        q.push_back(e);
        @(posedge clk);
        #1;
        // fields must have been captured at acceptance
        sbus.req_src    = 4'($urandom);
        sbus.req_dst    = 4'($urandom);
        sbus.req_imm_en = 1'($urandom);
        sbus.req_imm    = 8'($urandom);
        return;
      end
    end
    check_eq("accept_timeout", 64'(sbus.req_ready), 64'd1);
    sbus.req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    sbus.req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst             = 1'b1;
    sbus.req_valid  = 1'b1;
    sbus.req_src    = 4'd2;
    sbus.req_dst    = 4'd5;
    sbus.req_imm_en = 1'b0;
    sbus.req_imm    = 8'h00;

    // reset held with a pending request
    repeat (3) @(posedge clk);
    #1;
    rst            = 1'b0;
    sbus.req_valid = 1'b0;
    idle(2);

    send(4'd2, 4'd5, 1'b0, 8'h00);
    idle(6);

    send(4'd0, 4'd0, 1'b1, 8'hC3);
    idle(6);

    send(4'd3, 4'd3, 1'b0, 8'h00);
    idle(3);
    send(4'd1, 4'd9, 1'b0, 8'h00);
    idle(3);
    send(4'd0, 4'd8, 1'b1, 8'h11);
    idle(3);
    send(4'd12, 4'd1, 1'b0, 8'h00);
    idle(3);

    send(4'd1, 4'd6, 1'b0, 8'h00);
    send(4'd0, 4'd7, 1'b1, 8'h77);
    send(4'd6, 4'd3, 1'b0, 8'h00);
    idle(8);

    // abort during SET
    send(4'd4, 4'd1, 1'b0, 8'h00);
    idle(1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(6);
    send(4'd4, 4'd1, 1'b0, 8'h00);
    idle(6);

    for (int k = 0; k < 8; k++) begin
      send(4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
           1'($urandom_range(0, 1)), 8'($urandom_range(1, 255)));
    end
    idle(10);
    check_eq("queue_drained", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
